// File: rtl/button_pkg.sv
// Shared types and constants for the push-button command front end.
// Button indices double as arbitration priority (lower index wins).
package button_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_SEL   = 4;

endpackage

// File: rtl/btn_filter.sv
// One button: 2-FF synchronizer, tick-sampled history and debounced level.
// press/fall are combinational pulses valid during the tick that changes level.
module btn_filter #(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press,
  output logic fall
);

  logic                      sync_a;
  logic                      sync_b;
  logic [STABLE_SAMPLES-1:0] hist;
  logic [STABLE_SAMPLES-1:0] hist_next;

  assign hist_next = {hist[STABLE_SAMPLES-2:0], sync_b};
  assign press     = tick & (&hist_next) & ~level;
  assign fall      = tick & ~(|hist_next) & level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      hist   <= '0;
      level  <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      if (tick) begin
        hist <= hist_next;
        if (press)     level <= 1'b1;
        else if (fall) level <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/button_cmd_scheduler.sv
// Debounced push-button front end: auto-repeat for the last pressed button,
// one pending event per button, fixed-priority valid/ready command stream.
module button_cmd_scheduler
  import button_pkg::*;
#(
  parameter int N_BTN          = 5,
  parameter int SAMPLE_DIV     = 250000,
  parameter int STABLE_SAMPLES = 4,
  parameter int REPEAT_DELAY   = 125,
  parameter int REPEAT_RATE    = 25,
  localparam int IDW           = idw(N_BTN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             enable,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [IDW-1:0]   cmd_id,
  output logic             cmd_repeat,
  output logic [N_BTN-1:0] btn_level,
  output logic             overrun
);

  localparam int CW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = $clog2(RMAX + 1);

  logic [CW-1:0]    tick_cnt;
  logic             tick;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] fall;

  logic             rep_active;
  logic [IDW-1:0]   rep_tgt;
  logic [RCW-1:0]   rep_cnt;
  logic             any_press;
  logic [IDW-1:0]   press_idx;
  logic             rep_fire;
  logic [N_BTN-1:0] rep_vec;

  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] rep_flag;
  logic [N_BTN-1:0] set_vec;
  logic [N_BTN-1:0] clr_vec;
  logic [N_BTN-1:0] pend_next;
  logic [N_BTN-1:0] flag_next;
  logic             ovr_next;

  state_t           state;
  logic [IDW-1:0]   pick;
  logic             issue;

  assign tick = (tick_cnt == CW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + CW'(1);
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_filter
    btn_filter #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_filter (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .raw  (btn_in[g]),
      .level(btn_level[g]),
      .press(press[g]),
      .fall (fall[g])
    );
  end

  // Simultaneous presses retarget the engine to the highest-priority one.
  always_comb begin
    any_press = |press;
    press_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press[i]) press_idx = IDW'(i);
    end
  end

  assign rep_fire = tick & rep_active & ~any_press & (rep_cnt == RCW'(1))
                  & btn_level[rep_tgt] & ~fall[rep_tgt];

  always_comb begin
    rep_vec = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rep_vec[i] = rep_fire && (rep_tgt == IDW'(i));
    end
  end

  // rep_cnt counts down ticks; reaching 1 on a tick is a repeat instant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_active <= 1'b0;
      rep_tgt    <= '0;
      rep_cnt    <= '0;
    end else if (any_press) begin
      rep_active <= 1'b1;
      rep_tgt    <= press_idx;
      rep_cnt    <= RCW'(REPEAT_DELAY);
    end else if (tick && rep_active) begin
      if (fall[rep_tgt] || !btn_level[rep_tgt]) rep_active <= 1'b0;
      else if (rep_cnt == RCW'(1))               rep_cnt    <= RCW'(REPEAT_RATE);
      else                                       rep_cnt    <= rep_cnt - RCW'(1);
    end
  end

  always_comb begin
    pick = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pending[i]) pick = IDW'(i);
    end
    issue   = (state == IDLE) && enable && (|pending);
    clr_vec = '0;
    for (int i = 0; i < N_BTN; i++) begin
      clr_vec[i] = issue && (pick == IDW'(i));
    end
  end

  // A set landing on a bit being issued wins and is not an overrun.
  always_comb begin
    set_vec   = press | rep_vec;
    pend_next = (pending & ~clr_vec) | set_vec;
    flag_next = rep_flag;
    for (int i = 0; i < N_BTN; i++) begin
      if (press[i])        flag_next[i] = 1'b0;
      else if (rep_vec[i]) flag_next[i] = 1'b1;
    end
    ovr_next = |(set_vec & pending & ~clr_vec);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      rep_flag <= '0;
      overrun  <= 1'b0;
    end else begin
      pending  <= pend_next;
      rep_flag <= flag_next;
      overrun  <= ovr_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cmd_valid  <= 1'b0;
      cmd_id     <= '0;
      cmd_repeat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            cmd_valid  <= 1'b1;
            cmd_id     <= pick;
            cmd_repeat <= rep_flag[pick];
            state      <= OFFER;
          end
        end
        OFFER: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// Directed bench for button_cmd_scheduler with a fast tick (4 cycles) and
// short repeat timing; accepted commands are logged with their cycle number.
module tb_button_cmd_scheduler;
  import button_pkg::*;

  localparam int N_BTN = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_BTN-1:0] btn_in;
  logic             enable;
  logic             cmd_ready;
  logic             cmd_valid;
  logic [2:0]       cmd_id;
  logic             cmd_repeat;
  logic [N_BTN-1:0] btn_level;
  logic             overrun;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int n_valid = 0;
  int n_ovr   = 0;
  int n_unstable = 0;
  bit hold_chk = 1'b0;
  int log_id[$];
  int log_rep[$];
  int log_cyc[$];

  button_cmd_scheduler #(
    .N_BTN(N_BTN), .SAMPLE_DIV(4), .STABLE_SAMPLES(3),
    .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .enable(enable),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_id(cmd_id),
    .cmd_repeat(cmd_repeat), .btn_level(btn_level), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid) n_valid <= n_valid + 1;
      if (overrun) n_ovr <= n_ovr + 1;
      if (cmd_valid && cmd_ready) begin
        log_id.push_back(int'(cmd_id));
        log_rep.push_back(int'(cmd_repeat));
        log_cyc.push_back(cyc);
      end
      if (hold_chk && !(cmd_valid && cmd_id == 3'(BTN_SEL) && !cmd_repeat))
        n_unstable <= n_unstable + 1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise the masked buttons and wait (at most 14 cycles) for their levels.
  task automatic press_wait(input logic [N_BTN-1:0] mask, output int tp);
    bit seen = 1'b0;
    tp = 0;
    btn_in = btn_in | mask;
    for (int i = 0; i < 14 && !seen; i++) begin
      @(negedge clk);
      if ((btn_level & mask) == mask) begin
        seen = 1'b1;
        tp = cyc;
      end
    end
    n_total++;
    if (!seen) $display("FAIL level_rise mask=%b level=%b required rise within 14 cycles", mask, btn_level);
    else n_pass++;
  endtask

  task automatic release_now(input logic [N_BTN-1:0] mask);
    bit gone = 1'b0;
    btn_in = btn_in & ~mask;
    for (int i = 0; i < 20 && !gone; i++) begin
      @(negedge clk);
      if ((btn_level & mask) == '0) gone = 1'b1;
    end
    n_total++;
    if (!gone) $display("FAIL level_fall mask=%b level=%b required fall within 20 cycles", mask, btn_level);
    else n_pass++;
  endtask

  task automatic release_btns(input logic [N_BTN-1:0] mask);
    cycles(6);
    release_now(mask);
  endtask

  task automatic test_reset;
    int v0;
    reset = 1'b1; btn_in = '0; enable = 1'b1; cmd_ready = 1'b1;
    cycles(3);
    n_total++;
    if (cmd_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", cmd_valid); else n_pass++;
    n_total++;
    if (cmd_id !== 3'd0) $display("FAIL rst_id got=%0d exp=0", cmd_id); else n_pass++;
    n_total++;
    if (cmd_repeat !== 1'b0) $display("FAIL rst_repeat got=%b exp=0", cmd_repeat); else n_pass++;
    n_total++;
    if (btn_level !== 5'b0) $display("FAIL rst_level got=%b exp=00000", btn_level); else n_pass++;
    n_total++;
    if (overrun !== 1'b0) $display("FAIL rst_overrun got=%b exp=0", overrun); else n_pass++;
    reset = 1'b0;
    v0 = n_valid;
    cycles(20);
    n_total++;
    if (n_valid != v0) $display("FAIL idle_after_reset valid_cycles=%0d exp=0", n_valid - v0); else n_pass++;
  endtask

  task automatic test_bounce;
    int base, tp;
    base = log_id.size();
    cmd_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      btn_in[BTN_LEFT] = ((c / 3) % 2 == 0);
      @(negedge clk);
    end
    press_wait(5'b00100, tp);
    release_btns(5'b00100);
    cycles(40);
    n_total++;
    if (log_id.size() - base != 1) $display("FAIL bounce_count got=%0d exp=1", log_id.size() - base);
    else n_pass++;
    if (log_id.size() - base == 1) begin
      n_total++;
      if (log_id[base] != BTN_LEFT || log_rep[base] != 0)
        $display("FAIL bounce_cmd got id=%0d rep=%0d exp id=2 rep=0", log_id[base], log_rep[base]);
      else n_pass++;
    end
  endtask

  task automatic test_priority;
    int base, tp;
    base = log_id.size();
    cmd_ready = 1'b1;
    press_wait(5'b01010, tp);
    release_btns(5'b01010);
    cycles(30);
    n_total++;
    if (log_id.size() - base != 2) $display("FAIL prio_count got=%0d exp=2", log_id.size() - base);
    else n_pass++;
    if (log_id.size() - base == 2) begin
      n_total++;
      if (log_id[base] != 1 || log_id[base+1] != 3 || log_rep[base] != 0 || log_rep[base+1] != 0)
        $display("FAIL prio_order got ids=%0d,%0d reps=%0d,%0d exp ids=1,3 reps=0,0",
                 log_id[base], log_id[base+1], log_rep[base], log_rep[base+1]);
      else n_pass++;
      n_total++;
      if (log_cyc[base+1] - log_cyc[base] < 2)
        $display("FAIL prio_gap got=%0d cycles exp>=2", log_cyc[base+1] - log_cyc[base]);
      else n_pass++;
    end
  endtask

  task automatic test_auto_repeat;
    int base, tp;
    int exp_off[5] = '{1, 21, 29, 37, 45};
    base = log_id.size();
    cmd_ready = 1'b1;
    press_wait(5'b00001, tp);
    while (cyc < tp + 38) @(negedge clk);
    release_now(5'b00001);
    cycles(30);
    n_total++;
    if (log_id.size() - base != 5) $display("FAIL rpt_count got=%0d exp=5", log_id.size() - base);
    else n_pass++;
    if (log_id.size() - base == 5) begin
      for (int k = 0; k < 5; k++) begin
        n_total++;
        if (log_id[base+k] != 0 || log_rep[base+k] != (k > 0 ? 1 : 0) || log_cyc[base+k] - tp != exp_off[k])
          $display("FAIL rpt_cmd%0d got id=%0d rep=%0d at=+%0d exp id=0 rep=%0d at=+%0d", k,
                   log_id[base+k], log_rep[base+k], log_cyc[base+k] - tp, (k > 0 ? 1 : 0), exp_off[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure;
    int base, tp, o0;
    base = log_id.size();
    o0 = n_ovr;
    cmd_ready = 1'b0;
    press_wait(5'b10000, tp);
    @(negedge clk);
    n_total++;
    if (!(cmd_valid === 1'b1 && cmd_id === 3'd4 && cmd_repeat === 1'b0))
      $display("FAIL bp_offer got valid=%b id=%0d rep=%b exp valid=1 id=4 rep=0", cmd_valid, cmd_id, cmd_repeat);
    else n_pass++;
    hold_chk = 1'b1;
    release_btns(5'b10000);
    press_wait(5'b10000, tp);
    cycles(2);
    n_total++;
    if (n_ovr != o0) $display("FAIL bp_no_overrun got=%0d pulses exp=0", n_ovr - o0); else n_pass++;
    release_btns(5'b10000);
    press_wait(5'b10000, tp);
    cycles(2);
    n_total++;
    if (n_ovr - o0 != 1) $display("FAIL bp_overrun got=%0d pulse cycles exp=1", n_ovr - o0); else n_pass++;
    release_btns(5'b10000);
    hold_chk = 1'b0;
    n_total++;
    if (n_unstable != 0) $display("FAIL bp_stable got=%0d unstable cycles exp=0", n_unstable); else n_pass++;
    cmd_ready = 1'b1;
    cycles(20);
    n_total++;
    if (log_id.size() - base != 2) $display("FAIL bp_count got=%0d exp=2", log_id.size() - base);
    else n_pass++;
    if (log_id.size() - base == 2) begin
      n_total++;
      if (log_id[base+1] != 4 || log_rep[base+1] != 0)
        $display("FAIL bp_second got id=%0d rep=%0d exp id=4 rep=0", log_id[base+1], log_rep[base+1]);
      else n_pass++;
    end
  endtask

  task automatic test_enable;
    int base, tp, v0, start;
    base = log_id.size();
    cmd_ready = 1'b1;
    enable = 1'b0;
    v0 = n_valid;
    start = cyc;
    press_wait(5'b00010, tp);
    release_btns(5'b00010);
    while (cyc < start + 50) @(negedge clk);
    n_total++;
    if (n_valid != v0) $display("FAIL en_gate got=%0d valid cycles exp=0", n_valid - v0); else n_pass++;
    enable = 1'b1;
    @(negedge clk);
    n_total++;
    if (!(cmd_valid === 1'b1 && cmd_id === 3'd1 && cmd_repeat === 1'b0))
      $display("FAIL en_release got valid=%b id=%0d rep=%b exp valid=1 id=1 rep=0", cmd_valid, cmd_id, cmd_repeat);
    else n_pass++;
    cycles(10);
    n_total++;
    if (log_id.size() - base != 1) $display("FAIL en_count got=%0d exp=1", log_id.size() - base);
    else n_pass++;
  endtask

  task automatic test_reset_mid_offer;
    int base, tp, v0;
    cmd_ready = 1'b0;
    press_wait(5'b00100, tp);
    @(negedge clk);
    n_total++;
    if (cmd_valid !== 1'b1) $display("FAIL mid_offer_pre got valid=%b exp=1", cmd_valid); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++;
    if (cmd_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", cmd_valid); else n_pass++;
    n_total++;
    if (btn_level !== 5'b0) $display("FAIL mid_rst_level got=%b exp=00000", btn_level); else n_pass++;
    n_total++;
    if (overrun !== 1'b0) $display("FAIL mid_rst_overrun got=%b exp=0", overrun); else n_pass++;
    btn_in = '0;
    cycles(2);
    reset = 1'b0;
    cmd_ready = 1'b1;
    v0 = n_valid;
    cycles(30);
    n_total++;
    if (n_valid != v0) $display("FAIL mid_dropped got=%0d valid cycles exp=0", n_valid - v0); else n_pass++;
    base = log_id.size();
    press_wait(5'b01000, tp);
    release_btns(5'b01000);
    cycles(20);
    n_total++;
    if (log_id.size() - base != 1) $display("FAIL mid_restart_count got=%0d exp=1", log_id.size() - base);
    else n_pass++;
    if (log_id.size() - base == 1) begin
      n_total++;
      if (log_id[base] != BTN_RIGHT || log_rep[base] != 0)
        $display("FAIL mid_restart_cmd got id=%0d rep=%0d exp id=3 rep=0", log_id[base], log_rep[base]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_priority;
    test_auto_repeat;
    test_backpressure;
    test_enable;
    test_reset_mid_offer;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
